// File: rtl/beat_sequencer.sv
// ---------------------------------------------------------------------------
// beat_sequencer
//
// Purpose:
//   Beat (timing-pulse) generator for a simple CPU control unit. A start
//   pushbutton (QD) launches a free-running beat sequence W[1] -> W[2]
//   (-> W[3]) -> W[1] ... The control unit shortens or lengthens each
//   instruction with SHORT / LONG and halts the machine with STOP.
//   INSTR_CNT counts completed instructions and wraps from 255 to 0.
//   Every sequential element updates on the falling edge of T3.
//
// Ports:
//   T3         in   1  system clock (all state changes on falling edge)
//   CLR        in   1  asynchronous active-low reset
//   QD         in   1  start pushbutton, asynchronous to T3
//   SHORT      in   1  instruction ends after the W[1] beat
//   LONG       in   1  instruction needs a W[3] beat
//   STOP       in   1  halt after the current beat
//   STEP       in   1  single-instruction mode (only with SINGLE_STEP_EN)
//   W          out  3  one-hot beat W[1..3]; 000 while halted
//   RUN        out  1  high whenever the sequencer is not halted
//   INSTR_CNT  out  8  number of completed instructions (wraps)
//
// Build option:
//   SINGLE_STEP_EN  when defined, adds the STEP input. With STEP=1 every
//                   instruction end returns to HALT, so each QD press
//                   executes exactly one instruction.
// ---------------------------------------------------------------------------
module beat_sequencer (
  input  logic       T3,
  input  logic       CLR,
  input  logic       QD,
  input  logic       SHORT,
  input  logic       LONG,
  input  logic       STOP,
`ifdef SINGLE_STEP_EN
  input  logic       STEP,
`endif
  output logic [3:1] W,
  output logic       RUN,
  output logic [7:0] INSTR_CNT
);

  // State encoding equals the W pattern, so W is a straight copy of the
  // state register and carries no logic from any input.
  typedef enum logic [2:0] {
    HALT = 3'b000,
    B1   = 3'b001,
    B2   = 3'b010,
    B3   = 3'b100
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic       r_run;
  logic [7:0] r_instr_cnt;

  // Start-button synchronizer and edge detection.
  logic       r_qd_meta;
  logic       r_qd_sync;
  logic       r_qd_prev;
  logic [1:0] r_fill;
  logic       r_armed;

  logic       w_start;
  logic       w_instr_end;
  logic       w_step;

`ifdef SINGLE_STEP_EN
  assign w_step = STEP;
`else
  assign w_step = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // QD synchronizer. r_fill marks when r_qd_sync holds a genuine sample of
  // QD rather than its reset value: without it a button held down through
  // reset release would look like "sampled low, then rose" and start the
  // machine. ARMED is only set once a real low sample has been seen.
  // -------------------------------------------------------------------------
  always_ff @(negedge T3 or negedge CLR) begin
    if (!CLR) begin
      r_qd_meta <= 1'b0;
      r_qd_sync <= 1'b0;
      r_qd_prev <= 1'b0;
      r_fill    <= 2'b00;
      r_armed   <= 1'b0;
    end else begin
      r_qd_meta <= QD;
      r_qd_sync <= r_qd_meta;
      r_qd_prev <= r_qd_sync;
      r_fill    <= {r_fill[0], 1'b1};
      if (r_fill[1] && !r_qd_sync) begin
        r_armed <= 1'b1;
      end
    end
  end

  // Rising edge of the synchronized button. Only consumed in HALT, so a
  // press while running (or on the edge that enters HALT) is simply lost.
  assign w_start = r_armed & r_qd_sync & ~r_qd_prev;

  // -------------------------------------------------------------------------
  // Next-state logic. STOP has priority over SHORT/LONG; LONG only matters
  // in B2 and SHORT only in B1.
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_instr_end  = 1'b0;
    case (r_state)
      HALT: begin
        if (w_start) begin
          w_state_next = B1;
        end
      end
      B1: begin
        if (STOP) begin
          w_state_next = HALT;
        end else if (SHORT) begin
          w_state_next = B1;
        end else begin
          w_state_next = B2;
        end
      end
      B2: begin
        if (STOP) begin
          w_state_next = HALT;
        end else if (LONG) begin
          w_state_next = B3;
        end else begin
          w_state_next = B1;
        end
      end
      B3: begin
        if (STOP) begin
          w_state_next = HALT;
        end else begin
          w_state_next = B1;
        end
      end
      default: begin
        w_state_next = HALT;
      end
    endcase

    // An instruction ends whenever a running beat hands over to B1 or HALT.
    if ((r_state == B1 || r_state == B2 || r_state == B3) &&
        (w_state_next == B1 || w_state_next == HALT)) begin
      w_instr_end = 1'b1;
      // Single-step: park in HALT instead of starting the next instruction.
      if (w_step) begin
        w_state_next = HALT;
      end
    end
  end

  // -------------------------------------------------------------------------
  // State, RUN and instruction counter registers.
  // -------------------------------------------------------------------------
  always_ff @(negedge T3 or negedge CLR) begin
    if (!CLR) begin
      r_state     <= HALT;
      r_run       <= 1'b0;
      r_instr_cnt <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_run   <= (w_state_next != HALT);
      if (w_instr_end) begin
        r_instr_cnt <= r_instr_cnt + 8'd1;
      end
    end
  end

  assign W         = r_state;
  assign RUN       = r_run;
  assign INSTR_CNT = r_instr_cnt;

endmodule

// File: tb/tb_beat_sequencer.sv
// ---------------------------------------------------------------------------
// tb_beat_sequencer
//
// Directed test of beat_sequencer. Inputs change 1 ns after each falling
// edge of T3 and outputs are checked at that same point, well away from the
// next active (falling) edge. Expected values are hand-derived from the
// beat rules; exp_cnt tallies instruction ends as the steps are applied.
// Define SINGLE_STEP_EN to also exercise the single-step option.
// ---------------------------------------------------------------------------
module tb_beat_sequencer;

  logic       T3;
  logic       CLR;
  logic       QD;
  logic       SHORT;
  logic       LONG;
  logic       STOP;
`ifdef SINGLE_STEP_EN
  logic       STEP;
`endif
  logic [3:1] W;
  logic       RUN;
  logic [7:0] INSTR_CNT;

  int         total;
  int         bad;
  logic [7:0] exp_cnt;

  beat_sequencer dut (
    .T3        (T3),
    .CLR       (CLR),
    .QD        (QD),
    .SHORT     (SHORT),
    .LONG      (LONG),
    .STOP      (STOP),
`ifdef SINGLE_STEP_EN
    .STEP      (STEP),
`endif
    .W         (W),
    .RUN       (RUN),
    .INSTR_CNT (INSTR_CNT)
  );

  initial begin
    T3 = 1'b1;
    forever #5 T3 = ~T3;
  end

  // Safety net: the directed sequence is a few hundred cycles long.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge T3);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [2:0] w_exp,
                          input logic run_exp, input logic [7:0] cnt_exp);
    chk({tag, ".W"},   {5'd0, W},   {5'd0, w_exp});
    chk({tag, ".RUN"}, {7'd0, RUN}, {7'd0, run_exp});
    chk({tag, ".CNT"}, INSTR_CNT,   cnt_exp);
    $display("step %-16s W=%03b RUN=%0d CNT=%0d", tag, W, RUN, INSTR_CNT);
  endtask

  // Press QD and count falling edges until W[1] rises; it must take 2 or 3.
  task automatic press(input string tag);
    int k;
    QD = 1'b1;
    for (k = 1; k <= 4; k++) begin
      tick();
      if (W != 3'b000) break;
    end
    total++;
    assert (k >= 2 && k <= 3) else begin
      bad++;
      $error("FAIL %s.latency observed=%0d expected=2..3", tag, k);
    end
    chk({tag, ".W1"}, {5'd0, W}, 8'h01);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    exp_cnt = 8'd0;
    CLR   = 1'b0;
    QD    = 1'b0;
    SHORT = 1'b0;
    LONG  = 1'b0;
    STOP  = 1'b0;
`ifdef SINGLE_STEP_EN
    STEP  = 1'b0;
`endif

    // ---- reset state ----
    #3;
    chk_beat("reset", 3'b000, 1'b0, 8'd0);
    tick();
    tick();
    chk_beat("reset_hold", 3'b000, 1'b0, 8'd0);
    CLR = 1'b1;
    repeat (3) tick();
    chk_beat("idle", 3'b000, 1'b0, 8'd0);

    // ---- SHORT held: every beat is W[1] and ends an instruction ----
    SHORT = 1'b1;
    press("start_short");
    QD = 1'b0;
    chk_beat("short_b1", 3'b001, 1'b1, exp_cnt);
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_cnt++;
      chk_beat("short_loop", 3'b001, 1'b1, exp_cnt);
    end
    // STOP wins over SHORT in B1.
    STOP = 1'b1;
    tick();
    exp_cnt++;
    chk_beat("stop_b1", 3'b000, 1'b0, exp_cnt);
    STOP  = 1'b0;
    SHORT = 1'b0;

    // ---- beat sequence with LONG / SHORT ignore rules ----
    tick();
    chk_beat("idle2", 3'b000, 1'b0, exp_cnt);
    press("start_long");
    QD   = 1'b0;
    LONG = 1'b1;                    // ignored in B1
    tick();
    chk_beat("b1_to_b2", 3'b010, 1'b1, exp_cnt);
    SHORT = 1'b1;                   // ignored in B2, LONG takes effect
    tick();
    chk_beat("b2_to_b3", 3'b100, 1'b1, exp_cnt);
    LONG = 1'b0;                    // SHORT still high, ignored in B3
    tick();
    exp_cnt++;
    chk_beat("b3_to_b1", 3'b001, 1'b1, exp_cnt);
    LONG = 1'b1;                    // SHORT and LONG together in B1
    tick();
    exp_cnt++;
    chk_beat("both_b1", 3'b001, 1'b1, exp_cnt);
    SHORT = 1'b0;
    LONG  = 1'b0;
    tick();
    chk_beat("b1_to_b2b", 3'b010, 1'b1, exp_cnt);
    tick();
    exp_cnt++;
    chk_beat("b2_to_b1", 3'b001, 1'b1, exp_cnt);

    // ---- press while running is ignored, STOP in B2 halts ----
    QD = 1'b1;
    tick();
    chk_beat("run_press_b2", 3'b010, 1'b1, exp_cnt);
    tick();
    exp_cnt++;
    chk_beat("run_press_b1", 3'b001, 1'b1, exp_cnt);
    tick();
    chk_beat("run_press_b2b", 3'b010, 1'b1, exp_cnt);
    QD   = 1'b0;
    STOP = 1'b1;
    LONG = 1'b1;                    // STOP overrides LONG
    tick();
    exp_cnt++;
    chk_beat("stop_b2", 3'b000, 1'b0, exp_cnt);
    STOP = 1'b0;
    LONG = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk({"no_queue.W"}, {5'd0, W}, 8'h00);
    end
    press("restart");
    QD = 1'b0;
    chk_beat("restart_b1", 3'b001, 1'b1, exp_cnt);
    STOP = 1'b1;
    tick();
    exp_cnt++;
    chk_beat("stop_again", 3'b000, 1'b0, exp_cnt);
    STOP = 1'b0;

    // ---- QD held through reset release must not start ----
    QD  = 1'b1;
    CLR = 1'b0;
    #1;
    chk_beat("clr_async", 3'b000, 1'b0, 8'd0);
    exp_cnt = 8'd0;
    tick();
    tick();
    CLR = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk({"qd_held.W"}, {5'd0, W}, 8'h00);
    end
    QD = 1'b0;
    repeat (3) tick();
    press("after_clr");
    QD = 1'b0;
    chk_beat("after_clr_b1", 3'b001, 1'b1, 8'd0);

    // ---- counter wrap and mid-beat reset ----
    SHORT = 1'b1;
    repeat (255) tick();
    chk_beat("cnt_255", 3'b001, 1'b1, 8'd255);
    tick();
    chk_beat("cnt_wrap", 3'b001, 1'b1, 8'd0);
    tick();
    chk_beat("cnt_1", 3'b001, 1'b1, 8'd1);
    SHORT = 1'b0;
    tick();
    LONG = 1'b1;
    tick();
    chk_beat("in_b3", 3'b100, 1'b1, 8'd1);
    #3;
    CLR = 1'b0;
    #1;
    chk_beat("clr_mid_b3", 3'b000, 1'b0, 8'd0);
    LONG = 1'b0;
    tick();
    CLR = 1'b1;
    repeat (3) tick();

`ifdef SINGLE_STEP_EN
    // ---- single-step: one instruction per press ----
    STEP = 1'b1;
    for (int p = 1; p <= 2; p++) begin
      press("step_press");
      QD = 1'b0;
      chk_beat("step_b1", 3'b001, 1'b1, 8'(p - 1));
      tick();
      chk_beat("step_b2", 3'b010, 1'b1, 8'(p - 1));
      tick();
      chk_beat("step_halt", 3'b000, 1'b0, 8'(p));
      repeat (2) tick();
    end
    STEP = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/beat_sequencer.md
BEAT_SEQUENCER -- requirements
Module: beat_sequencer

Interface
REQ-001 Clock is T3 and reset is CLR; reset is asynchronous and active-low; there is one clock domain.
REQ-002 T3  input  1  system clock; all sequential elements update on the falling edge.
REQ-003 CLR  input  1  asynchronous active-low reset.
REQ-004 QD  input  1  start pushbutton, asynchronous to T3.
REQ-005 SHORT  input  1  instruction ends after the W1 beat (from the control unit).
REQ-006 LONG  input  1  instruction needs a W3 beat (from the control unit).
REQ-007 STOP  input  1  halt after the current beat (from the control unit).
REQ-008 W  output  3  one-hot beat, bit index 1..3 (W[1], W[2], W[3]); 000 when halted.
REQ-009 RUN  output  1  high whenever the state is not HALT.
REQ-010 INSTR_CNT  output  8  count of completed instructions.
REQ-011 STEP  input  1  single-instruction mode; present only when SINGLE_STEP_EN is defined.

Function
REQ-012 The FSM shall have exactly the states HALT, B1, B2 and B3; W shall be 000, 001, 010 and 100 in those states respectively.
REQ-013 QD shall pass through a two-flop synchronizer clocked by T3.
REQ-014 A start event is a synchronized 0->1 transition of QD while ARMED=1.
REQ-015 ARMED shall be set on the first falling edge of T3 at which the synchronized QD is 0.
REQ-016 HALT: on a start event the next state shall be B1; otherwise the FSM stays in HALT.
REQ-017 Start latency: W[1] shall rise 2 to 3 falling edges after QD rises.
REQ-018 B1: STOP -> HALT; else SHORT -> B1; else -> B2.
REQ-019 B2: STOP -> HALT; else LONG -> B3; else -> B1.
REQ-020 B3: STOP -> HALT; else -> B1.
REQ-021 Priority: STOP overrides SHORT and LONG.
REQ-022 LONG shall be ignored in B1 and SHORT shall be ignored in B2 and B3.
REQ-023 SHORT and LONG both high in B1 shall behave as SHORT alone.
REQ-024 SHORT, LONG and STOP shall be sampled at the falling edge of T3 that ends the beat.
REQ-025 Instruction end: any transition out of B1, B2 or B3 whose next state is B1 or HALT.
REQ-026 INSTR_CNT shall increment by 1 on every instruction end, including a STOP halt, and wrap from 255 to 0.
REQ-027 Start events while RUN=1 shall be ignored and shall not be queued.
REQ-028 A start event detected on the same edge as a transition into HALT shall be discarded.
REQ-029 W and RUN shall be driven directly from state registers, with no combinational path from any input.

Reset
REQ-030 CLR=0 shall immediately force state=HALT, W=000, RUN=0, INSTR_CNT=0, synchronizer flops=0 and ARMED=0, including mid-beat.
REQ-031 After CLR deasserts, a QD held high across reset release shall not start the FSM until QD has been sampled low and then rises again.

Configuration
REQ-032 Macro SINGLE_STEP_EN: when it is defined, port STEP exists.
REQ-033 With SINGLE_STEP_EN defined and STEP=1, every instruction end shall go to HALT instead of B1, so each QD press runs exactly one instruction.
REQ-034 With SINGLE_STEP_EN undefined, port STEP and its logic shall be absent and behaviour shall equal STEP=0.

Verification
REQ-035 Reset, then QD pulse with SHORT=1 held, STOP=0 -> W sequence 001,001,001...; INSTR_CNT increments every edge.
REQ-036 QD pulse with SHORT=0; LONG=1 during B2 only -> W 001,010,100,001; INSTR_CNT +1 per three beats.
REQ-037 STOP=1 asserted in B2 -> next W=000, RUN=0, INSTR_CNT +1; a second QD press while running is ignored, and a press after the halt restarts at 001.
REQ-038 Hold QD=1 through CLR release -> W stays 000; release QD, press again -> W=001 within 3 edges.
REQ-039 From INSTR_CNT=255, complete one instruction -> INSTR_CNT=0; assert CLR mid-B3 -> W=000 and INSTR_CNT=0 immediately.
REQ-040 With SINGLE_STEP_EN defined, STEP=1, SHORT=0, LONG=0 -> per QD press W 001,010,000, INSTR_CNT +1.
